// File: rtl/jstk_pkg.sv
// jstk_adjust shared types: direction and state enums
// plus PmodJSTK frame field positions.
package jstk_pkg;

  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  localparam int POS_W    = 10;
  localparam int FRAME_W  = 40;

  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;

  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;

endpackage

// File: rtl/jstk_adjust_if.sv
// jstk_adjust bus: joystick sample strobe in,
// adjust pulses and active flag out.
interface jstk_adjust_if;

  logic        sample_valid;
  logic [39:0] jstk_data;
  logic        inc_min;
  logic        dec_min;
  logic        inc_sec;
  logic        dec_sec;
  logic        active;

  modport master (
    output sample_valid,
    output jstk_data,
    input  inc_min,
    input  dec_min,
    input  inc_sec,
    input  dec_sec,
    input  active
  );

  modport slave (
    input  sample_valid,
    input  jstk_data,
    output inc_min,
    output dec_min,
    output inc_sec,
    output dec_sec,
    output active
  );

endinterface

// File: rtl/jstk_axis_decode.sv
// Combinational frame-to-direction decode with a
// centre deadzone; Y axis has priority over X.
module jstk_axis_decode
  import jstk_pkg::*;
#(
  parameter int CENTER   = 512,
  parameter int DEADZONE = 128
) (
  input  logic [39:0] jstk_data,
  output dir_t        dir
);

  localparam logic [POS_W:0] HI_TH =
    11'(CENTER + DEADZONE);
  localparam logic [POS_W:0] LO_TH =
    11'(CENTER - DEADZONE);

  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic x_hi, x_lo, y_hi, y_lo;
  logic unused_bits;

  assign x = {jstk_data[X_HI_MSB:X_HI_LSB],
              jstk_data[X_LO_MSB:X_LO_LSB]};
  assign y = {jstk_data[Y_HI_MSB:Y_HI_LSB],
              jstk_data[Y_LO_MSB:Y_LO_LSB]};

  assign x_hi = {1'b0, x} > HI_TH;
  assign x_lo = {1'b0, x} < LO_TH;
  assign y_hi = {1'b0, y} > HI_TH;
  assign y_lo = {1'b0, y} < LO_TH;

  assign unused_bits = ^{jstk_data[31:26],
                         jstk_data[15:10],
                         jstk_data[7:0]};

  // Priority pick: Y before X, boundaries neutral
  always_comb begin
    dir = NONE;
    priority case (1'b1)
      y_hi:    dir = UP;
      y_lo:    dir = DOWN;
      x_hi:    dir = RIGHT;
      x_lo:    dir = LEFT;
      default: dir = NONE;
    endcase
  end

endmodule

// File: rtl/jstk_adjust.sv
// Joystick to stopwatch adjust pulses with hold-to-repeat.
// Optional JSTK_ACCEL_EN speeds up repeats after ACCEL_AFTER.
module jstk_adjust
  import jstk_pkg::*;
#(
  parameter int CENTER        = 512,
  parameter int DEADZONE      = 128,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int ACCEL_AFTER   = 8
) (
  input  logic         clk,
  input  logic         rst,
  jstk_adjust_if.slave bus
);

  localparam int T_MAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW =
    (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] HOLD_LOAD =
    TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LOAD =
    TW'(REPEAT_CYCLES - 1);

`ifdef JSTK_ACCEL_EN
  localparam int CW = $clog2(ACCEL_AFTER + 1);
  localparam int FAST =
    (REPEAT_CYCLES / 4 < 1) ? 1 : REPEAT_CYCLES / 4;
  localparam logic [TW-1:0] FAST_LOAD =
    TW'(FAST - 1);
  localparam logic [CW-1:0] CNT_SAT =
    CW'(ACCEL_AFTER);

  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_cnt_n;
`else
  localparam int unused_accel = ACCEL_AFTER;
`endif

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  dir_t            cur_dir;
  dir_t            cur_dir_n;
  dir_t            dec_dir;
  dir_t            fire_dir;
  logic            strobe;
  logic            strobe_none;
  logic            strobe_new;

  jstk_axis_decode #(
    .CENTER   (CENTER),
    .DEADZONE (DEADZONE)
  ) u_decode (
    .jstk_data (bus.jstk_data),
    .dir       (dec_dir)
  );

  assign strobe      = bus.sample_valid;
  assign strobe_none = strobe && (dec_dir == NONE);
  assign strobe_new  = strobe && (dec_dir != NONE) &&
                       (dec_dir != cur_dir);

  // State, timer and latched direction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      cur_dir <= NONE;
`ifdef JSTK_ACCEL_EN
      rep_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      cur_dir <= cur_dir_n;
`ifdef JSTK_ACCEL_EN
      rep_cnt <= rep_cnt_n;
`endif
    end
  end

  // Next state: a strobe overrides a coincident expiry
  // unless it repeats the held direction
  always_comb begin
    state_n   = state;
    cur_dir_n = strobe ? dec_dir : cur_dir;
    fire_dir  = NONE;
    timer_n   = (timer != '0) ? timer - TW'(1) : timer;
`ifdef JSTK_ACCEL_EN
    rep_cnt_n = rep_cnt;
`endif
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (strobe && dec_dir != NONE) begin
          fire_dir = dec_dir;
          timer_n  = HOLD_LOAD;
          state_n  = HOLD;
`ifdef JSTK_ACCEL_EN
          rep_cnt_n = '0;
`endif
        end
      end
      HOLD, REPEAT: begin
        if (strobe_none) begin
          timer_n = '0;
          state_n = IDLE;
`ifdef JSTK_ACCEL_EN
          rep_cnt_n = '0;
`endif
        end else if (strobe_new) begin
          fire_dir = dec_dir;
          timer_n  = HOLD_LOAD;
          state_n  = HOLD;
`ifdef JSTK_ACCEL_EN
          rep_cnt_n = '0;
`endif
        end else if (timer == '0) begin
          fire_dir = cur_dir;
          state_n  = REPEAT;
          if (state == HOLD) begin
            timer_n = REP_LOAD;
          end else begin
`ifdef JSTK_ACCEL_EN
            if (rep_cnt != CNT_SAT)
              rep_cnt_n = rep_cnt + CW'(1);
            timer_n = (rep_cnt_n == CNT_SAT) ?
                      FAST_LOAD : REP_LOAD;
`else
            timer_n = REP_LOAD;
`endif
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Registered one-hot pulses and active flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.inc_min <= 1'b0;
      bus.dec_min <= 1'b0;
      bus.inc_sec <= 1'b0;
      bus.dec_sec <= 1'b0;
      bus.active  <= 1'b0;
    end else begin
      bus.inc_min <= (fire_dir == UP);
      bus.dec_min <= (fire_dir == DOWN);
      bus.inc_sec <= (fire_dir == RIGHT);
      bus.dec_sec <= (fire_dir == LEFT);
      bus.active  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_jstk_adjust.sv
// Self-checking bench for jstk_adjust: directed steps,
// then random strobes against an absolute-time model.
module tb_jstk_adjust;

  localparam int HOLD = 10;
  localparam int REP  = 4;
  localparam int ACC  = 2;
  localparam int HI   = 640;
  localparam int LO   = 384;

  logic clk = 1'b0;
  logic rst;

  jstk_adjust_if bus();

  jstk_adjust #(
    .CENTER        (512),
    .DEADZONE      (128),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .ACCEL_AFTER   (ACC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // obs/exp_o = {inc_min,dec_min,inc_sec,dec_sec,active}
  logic [4:0] obs;
  logic [4:0] exp_o;

  int     m_act, m_dir, m_inrep, m_rep;
  longint m_next, cyc_n;

  function automatic logic [39:0] mk(input int x,
                                     input int y);
    logic [39:0] d;
    logic [9:0]  xv, yv;
    xv = x[9:0];
    yv = y[9:0];
    d[39:8] = $urandom();
    d[7:0]  = 8'($urandom());
    d[39:32] = xv[7:0];
    d[25:24] = xv[9:8];
    d[23:16] = yv[7:0];
    d[9:8]   = yv[9:8];
    return d;
  endfunction

  // 0 none, 1 up, 2 down, 3 left, 4 right
  function automatic int dir_of(input logic [39:0] d);
    int x, y;
    x = int'({d[25:24], d[39:32]});
    y = int'({d[9:8], d[23:16]});
    if (y > HI) return 1;
    if (y < LO) return 2;
    if (x > HI) return 4;
    if (x < LO) return 3;
    return 0;
  endfunction

  task automatic model_edge(input logic s,
                            input logic [39:0] d,
                            input logic r);
    int  pd, dd, ivl;
    bit  fire, done;
    pd = 0;
    done = 0;
    if (r) begin
      m_act = 0; m_dir = 0; m_inrep = 0; m_rep = 0;
      m_next = 0;
      exp_o = '0;
      cyc_n++;
      return;
    end
    fire = (m_act != 0) && (cyc_n == m_next);
    if (s) begin
      dd = dir_of(d);
      if (dd == 0) begin
        m_act = 0;
        done = 1;
      end else if (m_act == 0 || dd != m_dir) begin
        pd = dd; m_act = 1; m_dir = dd;
        m_next = cyc_n + HOLD;
        m_inrep = 0; m_rep = 0;
        done = 1;
      end
    end
    if (!done && fire) begin
      pd = m_dir;
      ivl = REP;
      if (m_inrep == 0) begin
        m_inrep = 1;
      end else begin
`ifdef JSTK_ACCEL_EN
        if (m_rep < ACC) m_rep++;
        if (m_rep == ACC) ivl = (REP / 4 < 1) ? 1 : REP / 4;
`endif
      end
      m_next = cyc_n + ivl;
    end
    exp_o = {pd == 1, pd == 2, pd == 4, pd == 3,
             m_act != 0};
    cyc_n++;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, got, want);
    end
  endtask

  task automatic step(input logic s,
                      input logic [39:0] d,
                      input logic r);
    bus.sample_valid = s;
    bus.jstk_data    = d;
    rst              = r;
    @(posedge clk);
    model_edge(s, d, r);
    #1;
    obs = {bus.inc_min, bus.dec_min, bus.inc_sec,
           bus.dec_sec, bus.active};
    chk($sformatf("outputs@%0d", cyc_n), 64'(obs),
        64'(exp_o));
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, mk(512, 512), 1'b0);
      pulses += $countones(obs[4:1]);
    end
  endtask

  function automatic int pick();
    int vals[12];
    vals = '{0, 100, 383, 384, 385, 511,
             512, 639, 640, 641, 900, 1023};
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 1023));
    return vals[$urandom_range(0, 11)];
  endfunction

  int      n, cnt;
  int      tq[$];
  int      rx, ry;
  logic    rs, rr;
`ifndef JSTK_ACCEL_EN
  int      want5[5];
`endif

  initial begin
    bus.sample_valid = 1'b0;
    bus.jstk_data    = '0;
    rst              = 1'b1;
    m_act = 0; m_dir = 0; m_inrep = 0; m_rep = 0;
    m_next = 0; cyc_n = 0; exp_o = '0;

    // reset
    repeat (3) step(1'b0, mk(512, 512), 1'b1);
    chk("reset_outputs", 64'(obs), 64'(0));

    // single tap
    step(1'b1, mk(512, 800), 1'b0);
    chk("tap_pulse", 64'(obs), 64'(5'b10001));
    cnt = 1;
    step(1'b0, mk(512, 512), 1'b0);
    cnt += obs[4];
    step(1'b1, mk(512, 512), 1'b0);
    cnt += obs[4];
    chk("tap_active_fall", 64'(obs[0]), 64'(0));
    idle(12, n);
    chk("tap_count", 64'(cnt + n), 64'(1));

    // deadzone boundaries
    step(1'b1, mk(640, 512), 1'b0);
    cnt = $countones(obs[4:1]);
    step(1'b1, mk(384, 512), 1'b0);
    cnt += $countones(obs[4:1]);
    step(1'b1, mk(512, 640), 1'b0);
    cnt += $countones(obs[4:1]);
    idle(3, n);
    chk("deadzone_none", 64'(cnt + n), 64'(0));
    step(1'b1, mk(641, 512), 1'b0);
    chk("dz_641_inc_sec", 64'(obs), 64'(5'b00101));
    idle(2, n);
    step(1'b1, mk(383, 512), 1'b0);
    chk("dz_383_dec_sec", 64'(obs), 64'(5'b00011));
    step(1'b1, mk(512, 512), 1'b0);

    // hold and repeat
    tq.delete();
    for (int k = 0; k < 26; k++) begin
      step(k % 3 == 0, mk(512, 100), 1'b0);
      if (obs[3]) tq.push_back(k + 1);
    end
`ifndef JSTK_ACCEL_EN
    want5 = '{1, 11, 15, 19, 23};
    chk("hold_count", 64'(tq.size()), 64'(5));
    for (int i = 0; i < 5 && i < tq.size(); i++)
      chk($sformatf("hold_t%0d", i), 64'(tq[i]),
          64'(want5[i]));
`else
    chk("hold_count", 64'(tq.size()), 64'(11));
    if (tq.size() > 4)
      chk("accel_t5", 64'(tq[4]), 64'(20));
`endif

    // reset mid-REPEAT
    repeat (3) step(1'b0, mk(512, 100), 1'b1);
    chk("rst_active", 64'(obs[0]), 64'(0));
    idle(20, n);
    chk("rst_no_pulse", 64'(n), 64'(0));

    // priority and change on expiry
    step(1'b1, mk(900, 900), 1'b0);
    chk("prio_up", 64'(obs[4:1]), 64'(4'b1000));
    idle(9, n);
    step(1'b1, mk(100, 512), 1'b0);
    chk("chg_dec_sec", 64'(obs[4:1]), 64'(4'b0001));
    idle(9, n);
    chk("chg_gap", 64'(n), 64'(0));
    step(1'b0, mk(512, 512), 1'b0);
    chk("chg_next", 64'(obs[4:1]), 64'(4'b0001));
    step(1'b1, mk(512, 512), 1'b0);

    // same direction on expiry
    step(1'b1, mk(512, 900), 1'b0);
    cnt = obs[4];
    idle(9, n);
    cnt += n;
    step(1'b1, mk(512, 900), 1'b0);
    chk("same_dir_exp", 64'(obs[4:1]), 64'(4'b1000));
    cnt += obs[4];
    chk("same_dir_count", 64'(cnt), 64'(2));
    step(1'b1, mk(512, 512), 1'b0);

    // random
    rx = 512;
    ry = 512;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rx = pick();
      if ($urandom_range(0, 7) == 0) ry = pick();
      rs = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 99) == 0);
      step(rs, mk(rx, ry), rr);
      chk("onehot", 64'($countones(obs[4:1]) <= 1),
          64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/jstk_adjust.md
# jstk_adjust

Converts raw PmodJSTK samples into single-cycle adjust commands for the stopwatch counter. Each new 40-bit joystick frame is decoded into a deflection direction with a centre deadzone. The block then emits inc/dec pulses for the minutes field (Y axis) or the seconds field (X axis), with hold-to-repeat. It sits between the PmodJSTK interface (upstream) and the counter's adjust logic (downstream).

## Interface

Parameters:
- CENTER, 512: nominal 10-bit rest position of each axis.
- DEADZONE, 128: half-width of the no-action band around CENTER.
- HOLD_CYCLES, 50_000_000: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat pulses.
- ACCEL_AFTER, 8: number of repeat pulses before acceleration (JSTK_ACCEL_EN only).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. Synchronous, active-high.
- sample_valid, input, 1: one-cycle strobe indicating jstk_data holds a new frame.
- jstk_data, input, 40: raw PmodJSTK frame.
  - X = {jstk_data[25:24], jstk_data[39:32]}.
  - Y = {jstk_data[9:8], jstk_data[23:16]}.
- inc_min, output, 1: one-cycle pulse to increment minutes.
- dec_min, output, 1: one-cycle pulse to decrement minutes.
- inc_sec, output, 1: one-cycle pulse to increment seconds.
- dec_sec, output, 1: one-cycle pulse to decrement seconds.
- active, output, 1: high while a deflection is held (state ≠ IDLE).

## Operation

Direction decode happens only on cycles where sample_valid=1:
- An axis is high if pos > CENTER+DEADZONE.
- An axis is low if pos < CENTER-DEADZONE.
- Otherwise the axis is neutral. Comparisons are unsigned 10-bit; the boundary values themselves are neutral.
- Y has priority over X. Y high → UP, Y low → DOWN, else X high → RIGHT, X low → LEFT, else NONE.
- The decoded direction is latched in cur_dir. Between strobes, cur_dir holds.
- Direction-to-output mapping: UP → inc_min, DOWN → dec_min, RIGHT → inc_sec, LEFT → dec_sec.

State machine (states IDLE, HOLD, REPEAT):
- IDLE: when a strobe decodes a direction ≠ NONE:
  - issue that direction's pulse;
  - load timer = HOLD_CYCLES-1;
  - go to HOLD.
- HOLD: timer decrements every cycle. At timer==0:
  - issue a pulse;
  - load timer = REPEAT_CYCLES-1;
  - go to REPEAT.
- REPEAT: at timer==0, issue a pulse and reload REPEAT_CYCLES-1.
- From HOLD or REPEAT:
  - a strobe decoding NONE → IDLE, with no pulse;
  - a strobe decoding a different direction restarts as a fresh press: pulse the new direction, load HOLD_CYCLES-1, go to HOLD;
  - a strobe decoding the same direction has no effect on the timer.
- At most one of the four pulse outputs is high in any cycle.

## Timing

- All outputs are registered.
- Reset values: inc_min=dec_min=inc_sec=dec_sec=0, active=0, state=IDLE, timer=0, cur_dir=NONE, repeat count=0.
- Latency: a strobe at edge N produces its pulse at edge N+1 and active=1 at edge N+1.
- First repeat arrives HOLD_CYCLES cycles after the first pulse. Subsequent repeats are REPEAT_CYCLES apart.
- Simultaneous strobe and timer expiry: the strobe wins.
  - Different direction: only the new direction pulses, and the timer reloads HOLD.
  - NONE: no pulse.
  - Same direction: the expiry pulse is issued normally.
- rst asserted mid-hold: everything returns to reset values at that edge. A pulse that would have fired that cycle is suppressed.
- Timer width is $clog2 of the largest of HOLD_CYCLES and REPEAT_CYCLES. Values must be ≥1. A value of 1 pulses every cycle.

## Configuration

- JSTK_ACCEL_EN defined:
  - a repeat counter (width $clog2(ACCEL_AFTER+1)) counts REPEAT-state pulses, saturating at ACCEL_AFTER;
  - once saturated, reloads use REPEAT_CYCLES/4 (minimum 1);
  - the counter clears on entry to IDLE or HOLD.
- JSTK_ACCEL_EN undefined: the repeat interval is fixed at REPEAT_CYCLES, and neither the counter nor the ACCEL_AFTER logic exists.

## Structure

- Package jstk_pkg holds:
  - the direction enum (NONE, UP, DOWN, LEFT, RIGHT);
  - the state enum (IDLE, HOLD, REPEAT);
  - the X/Y bit-field extraction constants.
- Sub-module jstk_axis_decode: combinational. Takes jstk_data, CENTER and DEADZONE and returns the direction enum. It is instanced once, and verification can test it standalone.

## Test plan

Bench parameters: HOLD_CYCLES=10, REPEAT_CYCLES=4, ACCEL_AFTER=2.

- Reset: assert rst for 3 cycles mid-REPEAT → all outputs 0 at the next edge; no pulse for 20 cycles with sample_valid low.
- Single tap: one strobe with Y=800 (X=512), then a strobe with Y=512 two cycles later → exactly one inc_min pulse, one cycle after the first strobe; active falls after the second strobe.
- Deadzone boundary: strobes with X=640, X=384, Y=640 → no pulses. Strobe with X=641 → one inc_sec pulse. Strobe with X=383 → dec_sec behaves as a fresh press.
- Hold/repeat: strobe Y=100, then hold (Y=100 strobed every 3 cycles) → dec_min pulses at t=1, 11, 15, 19, 23. With JSTK_ACCEL_EN, pulses after the 2nd repeat come every cycle (4/4=1).
- Priority and direction change: strobe X=900, Y=900 → inc_min only. Strobe in the same cycle as a HOLD expiry with X=100, Y=512 → dec_sec pulse only, and the next pulse comes 10 cycles later.
- Simultaneous expiry and same direction: strobe Y=900 on the exact expiry cycle → exactly one inc_min pulse, with no duplicate.
